// File: rtl/add_header_seq_if.sv
// add_header_seq_if: AXI-Stream beat bundle (data, byte keep, last, valid/ready) for the header inserter ports.
interface add_header_seq_if #(parameter int DW = 128);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;
  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/add_header_seq.sv
// add_header_seq: buffers AXI-Stream packets and prepends a {oversize, seq, length} header beat, with per-packet bypass.
module add_header_seq_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(D);
  logic [W-1:0]  mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= push ? wp + 1'b1 : wp;
      rp  <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  assign rdata = mem[rp];
  assign empty = (cnt == '0);
  assign full  = cnt[AW];
endmodule

module add_header_seq #(
  parameter int DW         = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int HDR_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   hdr_en,
  add_header_seq_if.slave        axis_data,
  add_header_seq_if.master       axis_out,
  output logic [15:0]            seq_next
);
  localparam int KW  = DW / 8;
  localparam int DFW = DW + KW + 1;
  typedef enum logic {S_HDR, S_DATA} state_t;
  state_t          state_q, state_n;
  logic            d_full, d_empty, h_full, h_empty, d_pop, h_pop, h_push, acc;
  logic [DFW-1:0]  d_rd;
  logic [33:0]     h_rd, h_wr;
  logic [16:0]     pc, sum;
  logic [15:0]     len_q, len_n;
  logic            ov_q, ov_n, in_pkt, byp_q, byp;
  logic            out_valid, out_last, is_hdr, h_byp, d_last;
  logic [DW-1:0]   out_data;
  logic [KW-1:0]   out_keep;
  assign axis_data.tready = resetn && !d_full && !h_full;
  assign acc = axis_data.tvalid && axis_data.tready;
  always_comb begin
    pc = '0;
    for (int i = 0; i < KW; i++) pc = pc + 17'(axis_data.tkeep[i]);
  end
  // length saturates once the 17-bit running sum spills past 16 bits
  assign sum    = {1'b0, len_q} + pc;
  assign ov_n   = ov_q | sum[16];
  assign len_n  = ov_n ? 16'hFFFF : sum[15:0];
  assign byp    = in_pkt ? byp_q : !hdr_en;
  assign h_push = acc && axis_data.tlast;
  assign h_wr   = {byp, ov_n, seq_next, len_n};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      len_q    <= '0;
      ov_q     <= 1'b0;
      in_pkt   <= 1'b0;
      byp_q    <= 1'b0;
      seq_next <= '0;
    end else if (acc) begin
      len_q    <= axis_data.tlast ? '0 : len_n;
      ov_q     <= !axis_data.tlast && ov_n;
      in_pkt   <= !axis_data.tlast;
      byp_q    <= byp;
      seq_next <= seq_next + 16'(axis_data.tlast);
    end
  add_header_seq_fifo #(.W(DFW), .D(FIFO_DEPTH)) u_data_fifo (
    .clk(clk), .resetn(resetn), .push(acc),
    .wdata({axis_data.tdata, axis_data.tkeep, axis_data.tlast}),
    .pop(d_pop), .rdata(d_rd), .empty(d_empty), .full(d_full)
  );
  add_header_seq_fifo #(.W(34), .D(HDR_DEPTH)) u_hdr_fifo (
    .clk(clk), .resetn(resetn), .push(h_push), .wdata(h_wr),
    .pop(h_pop), .rdata(h_rd), .empty(h_empty), .full(h_full)
  );
  assign h_byp  = h_rd[33];
  assign d_last = d_rd[0];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= S_HDR;
    else state_q <= state_n;
  // a bypass entry is consumed without a handshake, leaving one idle cycle
  always_comb begin
    state_n = (state_q == S_HDR)
      ? ((!h_empty && (h_byp || axis_out.tready)) ? S_DATA : S_HDR)
      : ((!d_empty && axis_out.tready && d_last) ? S_HDR : S_DATA);
  end
  always_comb begin
    is_hdr    = (state_q == S_HDR);
    out_valid = is_hdr ? (!h_empty && !h_byp) : !d_empty;
    h_pop     = is_hdr && !h_empty && (h_byp || axis_out.tready);
    d_pop     = !is_hdr && !d_empty && axis_out.tready;
    out_data  = !out_valid ? '0 : is_hdr ? {{(DW-33){1'b0}}, h_rd[32:0]} : d_rd[DFW-1 -: DW];
    out_keep  = !out_valid ? '0 : is_hdr ? '1 : d_rd[KW:1];
    out_last  = out_valid && !is_hdr && d_last;
  end
  assign axis_out.tvalid = out_valid;
  assign axis_out.tdata  = out_data;
  assign axis_out.tkeep  = out_keep;
  assign axis_out.tlast  = out_last;
endmodule

// File: tb/tb_add_header_seq.sv
// tb_add_header_seq: directed scenarios for the header inserter, including an oversize run on a narrow deep build.
module tb_add_header_seq;
  typedef logic [144:0] beat_t;
  typedef logic [72:0]  beat2_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic hdr_en = 1'b1;
  logic [15:0] seq_next, seq_next2;
  int errors = 0;
  int checks = 0;
  beat_t  q[$];
  beat2_t q2[$];
  add_header_seq_if #(.DW(128)) in_if();
  add_header_seq_if #(.DW(128)) out_if();
  add_header_seq_if #(.DW(64))  in2_if();
  add_header_seq_if #(.DW(64))  out2_if();
  add_header_seq #(.DW(128), .FIFO_DEPTH(16), .HDR_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .hdr_en(hdr_en),
    .axis_data(in_if), .axis_out(out_if), .seq_next(seq_next)
  );
  add_header_seq #(.DW(64), .FIFO_DEPTH(16384), .HDR_DEPTH(2)) dut2 (
    .clk(clk), .resetn(resetn), .hdr_en(hdr_en),
    .axis_data(in2_if), .axis_out(out2_if), .seq_next(seq_next2)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (out_if.tvalid && out_if.tready) q.push_back({out_if.tlast, out_if.tkeep, out_if.tdata});
    if (out2_if.tvalid && out2_if.tready) q2.push_back({out2_if.tlast, out2_if.tkeep, out2_if.tdata});
  end
  function automatic beat_t hb(input logic [15:0] len, input logic [15:0] seq, input logic ov);
    return {1'b0, 16'hFFFF, 95'b0, ov, seq, len};
  endfunction
  function automatic beat_t db(input logic [127:0] d, input logic [15:0] k, input logic l);
    return {l, k, d};
  endfunction
  task automatic apply_reset();
    resetn = 1'b0;
    in_if.tvalid = 1'b0;
    in2_if.tvalid = 1'b0;
    out_if.tready = 1'b0;
    out2_if.tready = 1'b0;
    hdr_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    q.delete();
    q2.delete();
  endtask
  task automatic push(input logic [127:0] d, input logic [15:0] k, input logic l, input logic en);
    bit ok;
    int n = 0;
    in_if.tdata = d;
    in_if.tkeep = k;
    in_if.tlast = l;
    in_if.tvalid = 1'b1;
    hdr_en = en;
    do begin
      @(negedge clk);
      ok = in_if.tready;
      @(posedge clk);
      #2 n++;
    end while (!ok && n < 500);
    in_if.tvalid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout data=%h tready stayed 0", d);
    end
  endtask
  task automatic get_beat(output beat_t b, output bit ok);
    int n = 0;
    while (q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (q.size() != 0);
    b = ok ? q.pop_front() : 'x;
  endtask
  task automatic test_reset();
    in_if.tvalid = 1'b0;
    in2_if.tvalid = 1'b0;
    out_if.tready = 1'b0;
    out2_if.tready = 1'b0;
    #3;
    checks++;
    if ({in_if.tready, out_if.tvalid, out_if.tlast} !== 3'b000 || out_if.tdata !== '0 || out_if.tkeep !== '0 || seq_next !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got tready=%b tvalid=%b tdata=%h seq=%h required all 0", in_if.tready, out_if.tvalid, out_if.tdata, seq_next);
    end
  endtask
  task automatic test_basic();
    beat_t b;
    bit ok;
    beat_t e[4];
    apply_reset();
    out_if.tready = 1'b1;
    e = '{hb(16'h0028, 16'd0, 1'b0), db(128'hA0, 16'hFFFF, 1'b0), db(128'hB1, 16'hFFFF, 1'b0), db(128'hC2, 16'h00FF, 1'b1)};
    push(128'hA0, 16'hFFFF, 1'b0, 1'b1);
    push(128'hB1, 16'hFFFF, 1'b0, 1'b1);
    push(128'hC2, 16'h00FF, 1'b1, 1'b1);
    checks++;
    if (seq_next !== 16'd1) begin
      errors++;
      $display("FAIL basic_seq_next got %h required 0001", seq_next);
    end
    for (int i = 0; i < 4; i++) begin
      get_beat(b, ok);
      checks++;
      if (!ok || b !== e[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got %h required %h", i, b, e[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    beat_t b;
    bit ok;
    beat_t e[6];
    apply_reset();
    e = '{hb(16'd1, 16'd0, 1'b0), db(128'h11, 16'h0001, 1'b1), hb(16'd2, 16'd1, 1'b0), db(128'h22, 16'h0003, 1'b1),
          hb(16'd4, 16'd2, 1'b0), db(128'h33, 16'h000F, 1'b1)};
    push(128'h11, 16'h0001, 1'b1, 1'b1);
    push(128'h22, 16'h0003, 1'b1, 1'b1);
    push(128'h33, 16'h000F, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0 || out_if.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold got beats=%0d tvalid=%b required 0 and 1", q.size(), out_if.tvalid);
    end
    out_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      get_beat(b, ok);
      checks++;
      if (!ok || b !== e[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h required %h", i, b, e[i]);
      end
    end
  endtask
  task automatic test_bypass();
    beat_t b;
    bit ok;
    beat_t e[6];
    apply_reset();
    out_if.tready = 1'b1;
    e = '{hb(16'd8, 16'd0, 1'b0), db(128'hAA, 16'h00FF, 1'b1), db(128'hB0, 16'hFFFF, 1'b0), db(128'hB1, 16'h000F, 1'b1),
          hb(16'd2, 16'd2, 1'b0), db(128'hCC, 16'h0003, 1'b1)};
    push(128'hAA, 16'h00FF, 1'b1, 1'b1);
    push(128'hB0, 16'hFFFF, 1'b0, 1'b0);
    push(128'hB1, 16'h000F, 1'b1, 1'b1);
    push(128'hCC, 16'h0003, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      get_beat(b, ok);
      checks++;
      if (!ok || b !== e[i]) begin
        errors++;
        $display("FAIL bypass_beat%0d got %h required %h", i, b, e[i]);
      end
    end
    checks++;
    if (seq_next !== 16'd3) begin
      errors++;
      $display("FAIL bypass_seq_next got %h required 0003", seq_next);
    end
  endtask
  task automatic test_data_full();
    beat_t b;
    bit ok;
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      push(128'(i + 32'h500), 16'hFFFF, i == 15, 1'b1);
      if (i == 14) begin
        checks++;
        if (in_if.tready !== 1'b1) begin
          errors++;
          $display("FAIL dfull_15 tready got %b required 1", in_if.tready);
        end
      end
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (in_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL dfull_16 tready got %b required 0", in_if.tready);
    end
    out_if.tready = 1'b1;
    get_beat(b, ok);
    checks++;
    if (!ok || b !== hb(16'h0100, 16'd0, 1'b0)) begin
      errors++;
      $display("FAIL dfull_hdr got %h required %h", b, hb(16'h0100, 16'd0, 1'b0));
    end
    for (int i = 0; i < 16; i++) begin
      get_beat(b, ok);
      if (!ok || b !== db(128'(i + 32'h500), 16'hFFFF, i == 15)) bad++;
    end
    checks++;
    if (bad != 0 || in_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL dfull_drain got bad_beats=%0d tready=%b required 0 and 1", bad, in_if.tready);
    end
  endtask
  task automatic test_hdr_full();
    beat_t b, b2;
    bit ok, ok2;
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      push(128'(i + 32'h100), 16'h0001, 1'b1, 1'b1);
      if (i == 6) begin
        checks++;
        if (in_if.tready !== 1'b1) begin
          errors++;
          $display("FAIL hfull_7 tready got %b required 1", in_if.tready);
        end
      end
    end
    checks++;
    if (in_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL hfull_8 tready got %b required 0", in_if.tready);
    end
    out_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_beat(b, ok);
      get_beat(b2, ok2);
      if (!ok || !ok2 || b !== hb(16'd1, 16'(i), 1'b0) || b2 !== db(128'(i + 32'h100), 16'h0001, 1'b1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hfull_drain got bad_pairs=%0d required 0", bad);
    end
  endtask
  task automatic test_oversize();
    bit ok;
    bit stall = 1'b0;
    int n;
    int bad = 0;
    apply_reset();
    out2_if.tready = 1'b1;
    in2_if.tvalid = 1'b1;
    for (int i = 0; i <= 8750; i++) begin
      in2_if.tdata = (i == 8750) ? 64'hBEEF : 64'(i);
      in2_if.tkeep = (i == 8750) ? 8'h0F : 8'hFF;
      in2_if.tlast = (i >= 8749);
      n = 0;
      do begin
        @(negedge clk);
        ok = in2_if.tready;
        @(posedge clk);
        #2 n++;
      end while (!ok && n < 50);
      if (!ok) stall = 1'b1;
    end
    in2_if.tvalid = 1'b0;
    n = 0;
    while (q2.size() < 8753 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (stall || q2.size() != 8753) begin
      errors++;
      $display("FAIL ovs_count got stall=%b beats=%0d required 0 and 8753", stall, q2.size());
    end else begin
      checks++;
      if (q2[0] !== {1'b0, 8'hFF, 64'h0000_0001_0000_FFFF}) begin
        errors++;
        $display("FAIL ovs_hdr1 got %h required %h", q2[0], {1'b0, 8'hFF, 64'h0000_0001_0000_FFFF});
      end
      for (int i = 1; i <= 8750; i++)
        if (q2[i] !== {i == 8750, 8'hFF, 64'(i - 1)}) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL ovs_data got bad_beats=%0d required 0", bad);
      end
      checks++;
      if (q2[8751] !== {1'b0, 8'hFF, 64'h0000_0000_0001_0004} || q2[8752] !== {1'b1, 8'h0F, 64'hBEEF}) begin
        errors++;
        $display("FAIL ovs_next got %h %h required %h %h", q2[8751], q2[8752], {1'b0, 8'hFF, 64'h0000_0000_0001_0004}, {1'b1, 8'h0F, 64'hBEEF});
      end
    end
  endtask
  task automatic test_reset_mid();
    beat_t b;
    bit ok;
    apply_reset();
    push(128'hD0, 16'hFFFF, 1'b0, 1'b1);
    push(128'hD1, 16'hFFFF, 1'b1, 1'b1);
    push(128'hE0, 16'hFFFF, 1'b0, 1'b1);
    out_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #2 out_if.tready = 1'b0;
    checks++;
    if (q.size() != 2 || q[0] !== hb(16'd32, 16'd0, 1'b0) || out_if.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got beats=%0d tvalid=%b required 2 and 1", q.size(), out_if.tvalid);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({in_if.tready, out_if.tvalid, out_if.tlast} !== 3'b000 || out_if.tdata !== '0 || out_if.tkeep !== '0 || seq_next !== 16'd0) begin
      errors++;
      $display("FAIL rmid_async got tready=%b tvalid=%b tdata=%h seq=%h required all 0", in_if.tready, out_if.tvalid, out_if.tdata, seq_next);
    end
    #3 resetn = 1'b1;
    q.delete();
    @(posedge clk);
    #2 out_if.tready = 1'b1;
    push(128'hF7, 16'h0007, 1'b1, 1'b1);
    get_beat(b, ok);
    checks++;
    if (!ok || b !== hb(16'd3, 16'd0, 1'b0)) begin
      errors++;
      $display("FAIL rmid_hdr got %h required %h", b, hb(16'd3, 16'd0, 1'b0));
    end
    get_beat(b, ok);
    checks++;
    if (!ok || b !== db(128'hF7, 16'h0007, 1'b1)) begin
      errors++;
      $display("FAIL rmid_beat got %h required %h", b, db(128'hF7, 16'h0007, 1'b1));
    end
    repeat (6) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rmid_stale got extra_beats=%0d required 0", q.size());
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bypass();
    test_data_full();
    test_hdr_full();
    test_oversize();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
